// File: rtl/dma_pkg.sv
// Shared DMA definitions: issue-sequencer state encoding and the default
// transfer-size width common to the queue and dma_controller.
package dma_pkg;
  localparam int SIZE_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } dma_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read data. Pointers carry one extra
// wrap bit so full/empty/level fall out of plain pointer arithmetic.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_wr, do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr[AW-1:0]];
      end
    end
  end
endmodule

// File: rtl/dma_desc_queue.sv
// Descriptor queue feeding dma_controller: buffers size requests, issues one
// start pulse per nonzero entry, waits for done, and aborts via watchdog.
module dma_desc_queue
  import dma_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int SIZE_W  = SIZE_W_DEF,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic [SIZE_W-1:0]        req_size,
  output logic                     req_ready,
  output logic                     dma_start,
  output logic [SIZE_W-1:0]        dma_size,
  input  logic                     dma_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     zero_drop,
  output logic                     timeout,
  output logic [CNT_W-1:0]         xfer_count
);
  localparam int WD_W = $clog2(TIMEOUT) + 1;

  dma_state_t        state;
  logic [WD_W-1:0]   wdog;
  logic              pop_pend;
  logic              fifo_rd, fifo_full, fifo_empty;
  logic [SIZE_W-1:0] fifo_q;

  assign req_ready = !fifo_full;
  // Registered FIFO read: the head is examined one cycle after the pop.
  assign fifo_rd   = (state == IDLE) && !pop_pend && !fifo_empty;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(SIZE_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (req_valid),
    .wr_data (req_size),
    .rd_en   (fifo_rd),
    .rd_data (fifo_q),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      pop_pend   <= 1'b0;
      wdog       <= '0;
      dma_start  <= 1'b0;
      dma_size   <= '0;
      busy       <= 1'b0;
      zero_drop  <= 1'b0;
      timeout    <= 1'b0;
      xfer_count <= '0;
    end else begin
      dma_start <= 1'b0;
      zero_drop <= 1'b0;
      timeout   <= 1'b0;
      pop_pend  <= fifo_rd;
      case (state)
        IDLE: begin
          if (pop_pend) begin
            if (fifo_q != '0) begin
              dma_size  <= fifo_q;
              dma_start <= 1'b1;
              busy      <= 1'b1;
              state     <= ISSUE;
            end else begin
              zero_drop <= 1'b1;
            end
          end
        end
        ISSUE: begin
          wdog  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // done beats a simultaneous watchdog expiry
          if (dma_done) begin
            xfer_count <= xfer_count + 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (wdog == WD_W'(TIMEOUT - 1)) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_desc_queue.sv
// Directed bench for dma_desc_queue: reset, single transfer, full queue,
// watchdog abort, done/expiry race, mid-transfer reset, FIFO wrap order.
module tb_dma_desc_queue;
  localparam int DEPTH = 4, SIZE_W = 4, TIMEOUT = 64, CNT_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic [SIZE_W-1:0] req_size = '0;
  logic              req_ready;
  logic              dma_start;
  logic [SIZE_W-1:0] dma_size;
  logic              dma_done = 1'b0;
  logic              busy;
  logic [2:0]        level;
  logic              zero_drop;
  logic              timeout;
  logic [CNT_W-1:0]  xfer_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [SIZE_W-1:0] start_q[$];
  int zd_cnt = 0;
  int to_cnt = 0;

  dma_desc_queue #(.DEPTH(DEPTH), .SIZE_W(SIZE_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_size(req_size),
    .req_ready(req_ready), .dma_start(dma_start), .dma_size(dma_size),
    .dma_done(dma_done), .busy(busy), .level(level), .zero_drop(zero_drop),
    .timeout(timeout), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dma_start) start_q.push_back(dma_size);
    if (zero_drop) zd_cnt++;
    if (timeout) to_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic push(input logic [SIZE_W-1:0] s);
    req_valid = 1'b1;
    req_size  = s;
    step();
    req_valid = 1'b0;
  endtask

  task automatic do_done();
    dma_done = 1'b1;
    step();
    dma_done = 1'b0;
  endtask

  task automatic wait_start(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (dma_start) begin
        got = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    n_cmp++; if (level !== 3'd0)    begin n_bad++; $display("FAIL rst_level got %0d want 0", level); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b want 1", req_ready); end
    n_cmp++; if ({dma_start, busy, zero_drop, timeout} !== 4'b0000)
      begin n_bad++; $display("FAIL rst_flags got %b want 0000", {dma_start, busy, zero_drop, timeout}); end
    n_cmp++; if (dma_size !== 4'd0 || xfer_count !== 8'd0)
      begin n_bad++; $display("FAIL rst_regs got size=%0d cnt=%0d want 0/0", dma_size, xfer_count); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    int base;
    base = start_q.size();
    push(4'd4);
    n_cmp++; if (level !== 3'd1) begin n_bad++; $display("FAIL t1_level_push got %0d want 1", level); end
    step();
    n_cmp++; if (level !== 3'd0 || dma_start !== 1'b0 || busy !== 1'b0)
      begin n_bad++; $display("FAIL t1_pop got lvl=%0d st=%b busy=%b want 0/0/0", level, dma_start, busy); end
    step();
    n_cmp++; if (dma_start !== 1'b1 || dma_size !== 4'd4 || busy !== 1'b1)
      begin n_bad++; $display("FAIL t1_issue got st=%b size=%0d busy=%b want 1/4/1", dma_start, dma_size, busy); end
    step();
    n_cmp++; if (dma_start !== 1'b0 || busy !== 1'b1)
      begin n_bad++; $display("FAIL t1_wait got st=%b busy=%b want 0/1", dma_start, busy); end
    repeat (4) step();
    do_done();
    n_cmp++; if (busy !== 1'b0 || xfer_count !== 8'd1 || level !== 3'd0)
      begin n_bad++; $display("FAIL t1_done got busy=%b cnt=%0d lvl=%0d want 0/1/0", busy, xfer_count, level); end
    n_cmp++; if (start_q.size() - base !== 1 || dma_size !== 4'd4)
      begin n_bad++; $display("FAIL t1_starts got n=%0d size=%0d want 1/4", start_q.size() - base, dma_size); end
  endtask

  task automatic test_full();
    int base, zbase;
    bit got;
    logic [SIZE_W-1:0] exp [4];
    exp[0] = 4'd1; exp[1] = 4'd3; exp[2] = 4'd5; exp[3] = 4'd7;
    do_reset();
    base = start_q.size();
    zbase = zd_cnt;
    push(4'd1);
    wait_start(got);
    step();
    push(4'd3); push(4'd5); push(4'd0); push(4'd7);
    n_cmp++; if (level !== 3'd4 || req_ready !== 1'b0)
      begin n_bad++; $display("FAIL t2_full got lvl=%0d ready=%b want 4/0", level, req_ready); end
    req_valid = 1'b1;
    req_size  = 4'd9;
    step();
    step();
    req_valid = 1'b0;
    n_cmp++; if (level !== 3'd4) begin n_bad++; $display("FAIL t2_reject got lvl=%0d want 4", level); end
    do_done();
    for (int i = 0; i < 3; i++) begin
      wait_start(got);
      n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL t2_start_seen got %b want 1", got); end
      step();
      do_done();
    end
    n_cmp++; if (xfer_count !== 8'd4) begin n_bad++; $display("FAIL t2_count got %0d want 4", xfer_count); end
    n_cmp++; if (zd_cnt - zbase !== 1) begin n_bad++; $display("FAIL t2_zero_drop got %0d want 1", zd_cnt - zbase); end
    n_cmp++; if (start_q.size() - base !== 4) begin n_bad++; $display("FAIL t2_nstarts got %0d want 4", start_q.size() - base); end
    for (int i = 0; i < 4 && base + i < start_q.size(); i++) begin
      n_cmp++; if (start_q[base+i] !== exp[i])
        begin n_bad++; $display("FAIL t2_order[%0d] got %0d want %0d", i, start_q[base+i], exp[i]); end
    end
  endtask

  task automatic test_timeout();
    bit got;
    bit early;
    int tbase;
    do_reset();
    tbase = to_cnt;
    push(4'd2);
    push(4'd6);
    wait_start(got);
    step();
    early = 1'b0;
    for (int i = 0; i < 63; i++) begin
      step();
      if (timeout) early = 1'b1;
    end
    n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL t3_early got %b want 0", early); end
    step();
    n_cmp++; if (timeout !== 1'b1 || busy !== 1'b0)
      begin n_bad++; $display("FAIL t3_pulse got to=%b busy=%b want 1/0", timeout, busy); end
    step();
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL t3_one_cycle got %b want 0", timeout); end
    n_cmp++; if (xfer_count !== 8'd0) begin n_bad++; $display("FAIL t3_count got %0d want 0", xfer_count); end
    wait_start(got);
    n_cmp++; if (got !== 1'b1 || dma_size !== 4'd6)
      begin n_bad++; $display("FAIL t3_next got seen=%b size=%0d want 1/6", got, dma_size); end
    step();
    do_done();
    n_cmp++; if (to_cnt - tbase !== 1) begin n_bad++; $display("FAIL t3_ntimeouts got %0d want 1", to_cnt - tbase); end
  endtask

  task automatic test_done_race();
    bit got;
    int tbase;
    do_reset();
    tbase = to_cnt;
    push(4'd5);
    wait_start(got);
    step();
    repeat (63) step();
    do_done();
    n_cmp++; if (timeout !== 1'b0 || xfer_count !== 8'd1 || busy !== 1'b0)
      begin n_bad++; $display("FAIL t4_race got to=%b cnt=%0d busy=%b want 0/1/0", timeout, xfer_count, busy); end
    repeat (3) step();
    n_cmp++; if (to_cnt - tbase !== 0) begin n_bad++; $display("FAIL t4_ntimeouts got %0d want 0", to_cnt - tbase); end
  endtask

  task automatic test_reset_mid();
    bit got;
    int base;
    do_reset();
    push(4'd1);
    wait_start(got);
    step();
    push(4'd2);
    push(4'd3);
    n_cmp++; if (level !== 3'd2 || busy !== 1'b1)
      begin n_bad++; $display("FAIL t5_pre got lvl=%0d busy=%b want 2/1", level, busy); end
    reset = 1'b0;
    step();
    reset = 1'b1;
    base = start_q.size();
    do_done();
    n_cmp++; if (level !== 3'd0 || busy !== 1'b0 || xfer_count !== 8'd0)
      begin n_bad++; $display("FAIL t5_post got lvl=%0d busy=%b cnt=%0d want 0/0/0", level, busy, xfer_count); end
    repeat (10) step();
    n_cmp++; if (start_q.size() - base !== 0 || xfer_count !== 8'd0)
      begin n_bad++; $display("FAIL t5_quiet got starts=%0d cnt=%0d want 0/0", start_q.size() - base, xfer_count); end
  endtask

  task automatic test_back_to_back();
    bit got;
    int base;
    int nxt;
    do_reset();
    base = start_q.size();
    push(4'd1);
    wait_start(got);
    step();
    push(4'd2);
    push(4'd3);
    dma_done = 1'b1;
    step();
    dma_done = 1'b0;
    push(4'd4);
    n_cmp++; if (level !== 3'd2) begin n_bad++; $display("FAIL t6_pushpop got lvl=%0d want 2", level); end
    nxt = 5;
    for (int k = 0; k < 9; k++) begin
      wait_start(got);
      if (nxt <= 10 && req_ready) begin
        push(SIZE_W'(nxt));
        nxt++;
      end else begin
        step();
      end
      do_done();
    end
    n_cmp++; if (start_q.size() - base !== 10)
      begin n_bad++; $display("FAIL t6_nstarts got %0d want 10", start_q.size() - base); end
    for (int i = 0; i < 10 && base + i < start_q.size(); i++) begin
      n_cmp++; if (start_q[base+i] !== SIZE_W'(i + 1))
        begin n_bad++; $display("FAIL t6_order[%0d] got %0d want %0d", i, start_q[base+i], i + 1); end
    end
    n_cmp++; if (xfer_count !== 8'd10) begin n_bad++; $display("FAIL t6_count got %0d want 10", xfer_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_timeout();
    test_done_race();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
